// File: rtl/residu_pkg.sv
// residu_pkg: state encoding, ITU saturation constants and default sizes shared by the residual filter.
package residu_pkg;
  typedef enum logic [2:0] {IDLE, LDA, MAC, WR, DONE} state_t;
  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;
  localparam logic [31:0] ROUND_K = 32'h0000_8000;
  localparam int M_DEF = 10;
  localparam int LG_DEF = 40;
  localparam int AW_DEF = 11;
endpackage

// File: rtl/residu_filt_if.sv
// residu_filt_if: start/done handshake plus scratch-memory bus of residu_filt.
// The ovfl flag exists only when RESIDU_OVFL_EN is defined.
interface residu_filt_if #(parameter int AW = 11);
  logic start, done, memWriteEn;
  logic [AW-1:0] xAddr, aAddr, yAddr, memReadAddr, memWriteAddr;
  logic [31:0] memIn, memOut;
`ifdef RESIDU_OVFL_EN
  logic ovfl;
`endif
  modport master (
    output start, xAddr, aAddr, yAddr, memIn,
    input done, memReadAddr, memWriteAddr, memOut, memWriteEn
`ifdef RESIDU_OVFL_EN
    , ovfl
`endif
  );
  modport slave (
    input start, xAddr, aAddr, yAddr, memIn,
    output done, memReadAddr, memWriteAddr, memOut, memWriteEn
`ifdef RESIDU_OVFL_EN
    , ovfl
`endif
  );
endinterface

// File: rtl/residu_mac.sv
// residu_mac: one saturating L_mult/L_mac accumulate step, followed by the round(L_shl(.,3)) output stage.
// With RESIDU_OVFL_EN, ovfl reports any saturation; output-stage saturation counts only on the last term.
module residu_mac import residu_pkg::*; (
  input logic [31:0] s,
  input logic [15:0] a,
  input logic [15:0] x,
  input logic first,
`ifdef RESIDU_OVFL_EN
  input logic last,
  output logic ovfl,
`endif
  output logic [31:0] nextS,
  output logic [15:0] y16
);
  logic signed [31:0] prod;
  logic [31:0] mult;
  logic [32:0] sum;
  logic [15:0] shHi, yUp;
  logic multOv, macOv, shOv, shR, rOv;
  always_comb begin
    prod = 32'($signed(a)) * 32'($signed(x));
    multOv = a == 16'h8000 && x == 16'h8000;
    mult = multOv ? MAX_32 : prod <<< 1;
    sum = {s[31], s} + {mult[31], mult};
    macOv = !first && sum[32] != sum[31];
    nextS = first ? mult : macOv ? (sum[32] ? MIN_32 : MAX_32) : sum[31:0];
    shOv = nextS[31:28] != {4{nextS[31]}};
    // only the upper half of the shifted value and its bit 15 matter for round
    shHi = shOv ? (nextS[31] ? MIN_32[31:16] : MAX_32[31:16]) : nextS[28:13];
    shR = shOv ? !nextS[31] : nextS[12];
    yUp = shHi + {15'b0, shR & ROUND_K[15]};
    rOv = !shHi[15] && yUp[15];
    y16 = rOv ? MAX_32[31:16] : yUp;
`ifdef RESIDU_OVFL_EN
    ovfl = multOv || macOv || (last && (shOv || rOv));
`endif
  end
endmodule

// File: rtl/residu_filt.sv
// residu_filt: G.729 LPC residual y[n] = round(shl(sum a[j]*x[n-j], 3)) over a shared scratch memory.
// Defining RESIDU_OVFL_EN adds the sticky saturation flag bus.ovfl.
module residu_filt import residu_pkg::*; #(
  parameter int M = M_DEF,
  parameter int LG = LG_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk,
  input logic reset,
  residu_filt_if.slave bus
);
  localparam int CW = $clog2(M + 2);
  localparam int NW = $clog2(LG);
  state_t state;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n;
  logic [AW-1:0] xA, aA, yA, rdAddr, wrAddr;
  logic [31:0] acc, accNext, wrData;
  logic [15:0] aReg [M+1];
  logic [15:0] y16;
  logic wrEn, doneR;
  assign bus.memReadAddr = rdAddr;
  assign bus.memWriteAddr = wrAddr;
  assign bus.memOut = wrData;
  assign bus.memWriteEn = wrEn;
  assign bus.done = doneR;
`ifdef RESIDU_OVFL_EN
  logic ov, ovflR;
  assign bus.ovfl = ovflR;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovflR <= 1'b0;
    else if (state == IDLE && bus.start) ovflR <= 1'b0;
    else if (state == MAC && cnt != '0 && ov) ovflR <= 1'b1;
`endif
  // read data lags the issued address by one cycle, so the term for j arrives when cnt == j+1
  residu_mac uMac (
    .s(acc), .a(aReg[cnt - CW'(1)]), .x(bus.memIn[15:0]), .first(cnt == CW'(1)),
`ifdef RESIDU_OVFL_EN
    .last(cnt == CW'(M + 1)), .ovfl(ov),
`endif
    .nextS(accNext), .y16(y16)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      xA <= '0;
      aA <= '0;
      yA <= '0;
      acc <= '0;
      rdAddr <= '0;
      wrAddr <= '0;
      wrData <= '0;
      wrEn <= 1'b0;
      doneR <= 1'b0;
      for (int i = 0; i <= M; i++) aReg[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= LDA;
          cnt <= '0;
          n <= '0;
          xA <= bus.xAddr;
          aA <= bus.aAddr;
          yA <= bus.yAddr;
          rdAddr <= bus.aAddr;
        end
        LDA: begin
          cnt <= cnt + CW'(1);
          if (cnt < CW'(M)) rdAddr <= aA + AW'(cnt) + AW'(1);
          if (cnt != '0) aReg[cnt - CW'(1)] <= bus.memIn[15:0];
          if (cnt == CW'(M + 1)) begin
            state <= MAC;
            cnt <= '0;
            rdAddr <= xA;
          end
        end
        MAC: begin
          cnt <= cnt + CW'(1);
          if (cnt < CW'(M)) rdAddr <= xA + AW'(n) - AW'(cnt) - AW'(1);
          if (cnt != '0) acc <= accNext;
          if (cnt == CW'(M + 1)) begin
            state <= WR;
            wrEn <= 1'b1;
            wrAddr <= yA + AW'(n);
            wrData <= {{16{y16[15]}}, y16};
          end
        end
        WR: begin
          wrEn <= 1'b0;
          cnt <= '0;
          if (n == NW'(LG - 1)) begin
            state <= DONE;
            doneR <= 1'b1;
          end else begin
            state <= MAC;
            n <= n + NW'(1);
            rdAddr <= xA + AW'(n) + AW'(1);
          end
        end
        DONE: begin
          doneR <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_residu_filt.sv
// tb_residu_filt: directed frames checked against a scoreboard of ITU-modelled residual writes.
`timescale 1ns/1ps
module tb_residu_filt;
  logic clk = 1'b0;
  logic reset = 1'b0;
  residu_filt_if #(.AW(11)) bus();
  residu_filt dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [2048];
  logic [42:0] q [$];
  int checks = 0, errors = 0, cyc = 0, t0 = 0, wrCount = 0, lastWr = 0, doneCount = 0, mOv = 0;
  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.memIn <= mem[bus.memReadAddr];
    if (bus.memWriteEn) mem[bus.memWriteAddr] = bus.memOut;
  end
  always @(negedge clk) begin
    logic [42:0] e;
    if (bus.memWriteEn) begin
      wrCount++;
      chk("sb_pending", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", bus.memWriteAddr, e[42:32]);
        chk("wr_data", bus.memOut, e[31:0]);
      end
      chk("wr_timing", cyc - t0 - lastWr, (wrCount == 1) ? 25 : 13);
      lastWr = cyc - t0;
    end
    if (bus.done) doneCount++;
  end
  function automatic longint sat32(longint v);
    if (v > 64'sd2147483647) begin mOv = 1; return 64'sd2147483647; end
    if (v < -64'sd2147483648) begin mOv = 1; return -64'sd2147483648; end
    return v;
  endfunction
  task automatic model(input logic [10:0] xa, aa, ya);
    logic [31:0] mm [2048];
    logic [10:0] ad;
    logic [15:0] y;
    longint s, p;
    mm = mem;
    mOv = 0;
    for (int n = 0; n < 40; n++) begin
      s = 0;
      for (int j = 0; j <= 10; j++) begin
        ad = xa + 11'(n) - 11'(j);
        p = sat32(2 * longint'($signed(mm[aa + 11'(j)][15:0])) * longint'($signed(mm[ad][15:0])));
        s = (j == 0) ? p : sat32(s + p);
      end
      s = sat32(sat32(s * 8) + 32768);
      y = 16'(s >>> 16);
      ad = ya + 11'(n);
      mm[ad] = {{16{y[15]}}, y};
      q.push_back({ad, mm[ad]});
    end
  endtask
  task automatic setA(input logic [10:0] aa, input int a0, a1, rest);
    mem[aa] = a0;
    mem[aa + 11'd1] = a1;
    for (int j = 2; j <= 10; j++) mem[aa + 11'(j)] = rest;
  endtask
  task automatic setX(input logic [10:0] xa, input int v, input bit rnd);
    for (int k = -10; k < 40; k++) mem[xa + 11'(k)] = rnd ? int'($urandom_range(0, 65535)) - 32768 : v;
  endtask
  task automatic run_frame(input logic [10:0] xa, aa, ya, input int busyAt, rstAt);
    int doneAt, held;
    logic ovAtDone;
    doneAt = -1;
    ovAtDone = 1'b0;
    model(xa, aa, ya);
    wrCount = 0;
    lastWr = 0;
    doneCount = 0;
    bus.xAddr = xa;
    bus.aAddr = aa;
    bus.yAddr = ya;
    t0 = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.xAddr = ~xa;
    bus.aAddr = ~aa;
    bus.yAddr = ~ya;
    for (int i = 1; i < 700 && doneAt < 0; i++) begin
      if (i == rstAt) begin
        reset = 1'b0;
        #1;
        chk("rst_we", bus.memWriteEn, 1'b0);
        chk("rst_rd", bus.memReadAddr, 11'h0);
        chk("rst_wa", bus.memWriteAddr, 11'h0);
        chk("rst_out", bus.memOut, 32'h0);
        chk("rst_done", bus.done, 1'b0);
        held = wrCount;
        repeat (20) @(negedge clk);
        chk("rst_no_writes", wrCount, held);
        q.delete();
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      bus.start = (i == busyAt);
      @(negedge clk);
      if (bus.done) begin
        doneAt = i + 1;
        ovAtDone = 1'b0;
`ifdef RESIDU_OVFL_EN
        ovAtDone = bus.ovfl;
`endif
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_cycle", doneAt, 533);
    chk("write_count", wrCount, 40);
    chk("done_pulses", doneCount, 1);
    chk("sb_drained", q.size(), 0);
`ifdef RESIDU_OVFL_EN
    chk("ovfl", ovAtDone, 1'(mOv));
`endif
  endtask
  initial begin
    logic [31:0] x39;
    bus.start = 1'b0;
    bus.xAddr = '0;
    bus.aAddr = '0;
    bus.yAddr = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_we", bus.memWriteEn, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_rd", bus.memReadAddr, 11'h0);
    chk("reset_wa", bus.memWriteAddr, 11'h0);
    chk("reset_out", bus.memOut, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    setA(11'd100, 4096, 0, 0);
    setX(11'd300, 1000, 1'b0);
    run_frame(11'd300, 11'd100, 11'd500, -1, -1);
    chk("identity_y5", mem[505], 32'd1000);
    setA(11'd100, 4096, -4096, 0);
    setX(11'd300, 0, 1'b1);
    for (int k = -10; k < 40; k++) mem[11'd300 + 11'(k)] = int'($urandom_range(0, 20000)) - 10000;
    mem[299] = 500;
    mem[300] = 700;
    mem[301] = 900;
    run_frame(11'd300, 11'd100, 11'd600, -1, -1);
    chk("history_y0", mem[600], 32'd200);
    chk("history_y1", mem[601], 32'd200);
    setA(11'd100, 4096, 4096, 4096);
    setX(11'd300, 32767, 1'b0);
    run_frame(11'd300, 11'd100, 11'd700, -1, -1);
    chk("sat_pos_y0", mem[700], 32'd32767);
    setA(11'd100, 4096, 0, 0);
    setX(11'd300, -32768, 1'b0);
    run_frame(11'd300, 11'd100, 11'd700, -1, -1);
    chk("sat_neg_y39", mem[739], 32'hFFFF_8000);
    setA(11'd100, -32768, 0, 0);
    setX(11'd300, -32768, 1'b0);
    run_frame(11'd300, 11'd100, 11'd750, -1, -1);
    chk("mult_sat_y0", mem[750], 32'd32767);
    setA(11'd100, 3000, -1500, 300);
    setX(11'd300, 0, 1'b1);
    run_frame(11'd300, 11'd100, 11'd900, 100, -1);
    setA(11'd100, 2048, 1024, -512);
    setX(11'd300, 0, 1'b1);
    run_frame(11'd300, 11'd100, 11'd800, -1, 200);
    run_frame(11'd300, 11'd100, 11'd800, -1, -1);
    setA(11'd100, 4096, 0, 0);
    setX(11'h7FC, 0, 1'b1);
    x39 = mem[11'h023];
    run_frame(11'h7FC, 11'd100, 11'h7FC, -1, -1);
    chk("wrap_y39", mem[11'h023], {{16{x39[15]}}, x39[15:0]});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/residu_filt.md
Name: residu_filt

Overview:
- Computes the G.729 LPC residual (inverse A(z) filtering): y[n] = round(shl(sum_{j=0..M} a[j]*x[n-j], 3)).
- Produces the excitation/residual frame consumed directly by the synthesis filter stage.
- Sits upstream of the synthesis filter and shares the same scratch memory, with a start/done handshake from the top-level sequencer.
- All ITU basic-op arithmetic (L_mult, L_mac, L_shl, round) is implemented internally with exact saturation semantics.

Parameters:
- M, 10, LPC order; a[0..M] are Q12.
- LG, 40, number of output samples per start.
- AW, 11, scratch memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- xAddr  in  AW  address of x[0]; history x[-1..-M] sits at xAddr-1..xAddr-M.
- aAddr  in  AW  address of a[0]; a[j] at aAddr+j.
- yAddr  in  AW  address of y[0]; y[n] at yAddr+n.
- memIn  in  32  scratch read data, 1-cycle synchronous latency; operand is memIn[15:0].
- memReadAddr  out  AW  scratch read address.
- memWriteAddr  out  AW  scratch write address.
- memOut  out  32  write data, y sign-extended to 32 bits.
- memWriteEn  out  1  write strobe.
- done  out  1  high one cycle on completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; all registers 0.
- Address arithmetic is modulo 2^AW; no wrap detection.
- xAddr, aAddr and yAddr are latched on start; later changes are ignored.
- IDLE: on start, move to LDA. start while not in IDLE is ignored.
- LDA: issue reads aAddr+0..aAddr+M on consecutive cycles. Capture each coefficient into register bank a_reg[0..M] one cycle later. Takes M+2 cycles, then go to MAC with n=0.
- MAC: issue reads xAddr+n-j for j=0..M, one per cycle.
  - Accumulator: s=L_mult(x,a[0]) on the first returned word, then s=L_mac(s,a[j],x) for each subsequent word.
  - Takes M+1 issue cycles plus 1 drain cycle, then go to WR.
- WR: assert memWriteEn for exactly one cycle with memWriteAddr=yAddr+n and memOut=sext(round(L_shl(s,3))).
  - If n==LG-1, go to DONE; else n++ and return to MAC.
- DONE: done=1 for one cycle, then IDLE.
- Timing is exact. With start sampled at cycle 0:
  - first write occurs at cycle (M+2)+(M+2)+1 = 25;
  - writes are spaced M+3 = 13 cycles apart;
  - done is high at cycle 12+13*LG+1 = 533 for the defaults.
- Arithmetic:
  - L_mult(a,b) = sat32(a*b*2); 0x8000*0x8000 gives 0x7FFFFFFF.
  - L_mac = sat32(s + L_mult).
  - L_shl(s,3) saturates to 0x7FFFFFFF or 0x80000000 when bits are lost.
  - round(s) = upper 16 bits of sat32(s+0x8000).
- memWriteEn is never asserted outside WR.
- memReadAddr holds its last value when no read is issued.
- reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial write completes after reset asserts.
- Write/read collision: WR never overlaps a read issue, so in-place operation (yAddr==xAddr) is hazard-free for sample n. The result is still numerically the in-place ITU behaviour, because later reads see the overwritten y.

Optional Feature:
- Macro RESIDU_OVFL_EN.
- Defined:
  - Adds output port ovfl (1 bit).
  - ovfl is a sticky flag, set when any L_mult, L_mac, L_shl or round saturates during the run.
  - Cleared on start and on reset; valid when done is high.
- Undefined: the port and the logic are absent; arithmetic results are identical in both cases.

Decomposition:
- Package residu_pkg holds:
  - state encoding (IDLE, LDA, MAC, WR, DONE);
  - MAX_32=32'h7FFF_FFFF, MIN_32=32'h8000_0000, ROUND_K=32'h0000_8000;
  - default M and LG.
- Sub-module residu_mac:
  - combinational saturating L_mult/L_mac/L_shl3/round datapath;
  - inputs s, a, x and first-term flag;
  - outputs next s, y16 and an overflow bit.
- The FSM, counters and coefficient bank stay in residu_filt.

Test Plan:
- Identity: a[0]=4096, a[1..10]=0, x[n]=1000 for all n -> y[0..39]=1000; done at cycle 533; exactly 40 memWriteEn pulses at 13-cycle spacing.
- History use: a[0]=4096, a[1]=-4096, x[-1]=500, x[0]=700, x[1]=900 -> y[0]=200, y[1]=200.
- Saturation: a[0..10]=4096, all x=32767 -> every y=32767. Then a[0]=4096, rest 0, x=-32768 -> y=-32768. With RESIDU_OVFL_EN defined, ovfl=1 on the first case and 0 on the second.
- Start while busy: second start pulse at cycle 100 -> ignored; a single done at cycle 533; write count stays 40.
- Reset mid-run: reset low at cycle 200 -> all outputs 0 immediately, no further writes. A new start after release -> full correct frame, done 533 cycles later.
- In-place and wrap: yAddr=xAddr=11'h7FC with history at 11'h7F2..11'h7FB, a[0]=4096 -> addresses wrap through 0x000; y[n]=x[n]; no out-of-range access.
